// File: rtl/bus_slave_mem_if.sv
// Bus slave interface: select/direction/address/write data in, registered read data and completion pulses out.
interface bus_slave_mem_if;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout;
    logic        S_ack;
    logic        S_err;

    modport master (
        output S_sel, S_wr, S_address, S_din,
        input  S_dout, S_ack, S_err
    );

    modport slave (
        input  S_sel, S_wr, S_address, S_din,
        output S_dout, S_ack, S_err
    );
endinterface

// File: rtl/bus_slave_mem.sv
// 32x32 memory slave with programmable wait states; requests are captured on select and completed with ack or err.
module bus_slave_mem #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    bus_slave_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
    localparam logic [8:0] ADDR_LO   = {1'b0, BASE_ADDR};

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_q, dout_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [32];
    logic        mem_we;
    logic [8:0]  offset;
    logic        in_range;
    logic [4:0]  idx;

    // 9-bit offset: an address below the base wraps to >= 257, so one bound check covers both ends.
    assign offset   = {1'b0, addr_q} - ADDR_LO;
    assign in_range = (offset[8:5] == '0);
    assign idx      = offset[4:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.S_sel) begin
                    wr_d    = bus.S_wr;
                    addr_d  = bus.S_address;
                    wdata_d = bus.S_din;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (!bus.S_sel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 3'd1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.S_sel) begin
                    if (in_range) begin
                        ack_d = 1'b1;
                        if (wr_q) begin
                            mem_we = 1'b1;
                        end else begin
                            dout_d = mem_q[idx];
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.S_dout = dout_q;
    assign bus.S_ack  = ack_q;
    assign bus.S_err  = err_q;
endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: four instances with different base/wait settings share clock and reset.
module tb_bus_slave_mem;
    localparam int N = 4;
    localparam logic [7:0] BASES [N] = '{8'h00, 8'h20, 8'h00, 8'h00};
    localparam int         WAITS [N] = '{1, 1, 3, 0};

    typedef struct {
        int          k;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic        ack;
        logic        err;
        logic [31:0] dout;
        int          lat;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          sel, wr, ackv, errv;
    logic [N-1:0][7:0]     addr;
    logic [N-1:0][31:0]    din, doutv;
    int                    n_checks = 0;
    int                    n_pass   = 0;
    vec_t                  tbl [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_slave_mem_if bus ();
        assign bus.S_sel     = sel[g];
        assign bus.S_wr      = wr[g];
        assign bus.S_address = addr[g];
        assign bus.S_din     = din[g];
        assign doutv[g]      = bus.S_dout;
        assign ackv[g]       = bus.S_ack;
        assign errv[g]       = bus.S_err;
        bus_slave_mem #(.BASE_ADDR(BASES[g]), .WAIT_CYCLES(WAITS[g])) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // Called at a negedge; returns at the negedge where ack/err is seen, lat = edges after capture.
    task automatic xfer(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                        output int lat);
        sel[k]  = 1'b1;
        wr[k]   = w;
        addr[k] = a;
        din[k]  = d;
        @(posedge clk);
        lat = 0;
        while (lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ackv[k] || errv[k]) break;
        end
        sel[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat;
        int    k;
        logic  seen;
        string tag;

        reset = 1'b1;
        sel   = '0;
        wr    = '0;
        addr  = '0;
        din   = '0;
        #2;
        for (int i = 0; i < N; i++)
            check($sformatf("reset_out%0d", i), {ackv[i], errv[i], doutv[i]}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // k, wr, addr, data, ack, err, dout, latency
        tbl.push_back('{0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 2});
        tbl.push_back('{0, 1'b0, 8'h05, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF, 2});
        tbl.push_back('{0, 1'b1, 8'h1F, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF, 2});
        tbl.push_back('{0, 1'b0, 8'h1F, 32'h00000000, 1'b1, 1'b0, 32'hA5A5A5A5, 2});
        tbl.push_back('{0, 1'b1, 8'h00, 32'h11111111, 1'b1, 1'b0, 32'hA5A5A5A5, 2});
        tbl.push_back('{0, 1'b1, 8'h07, 32'h77777777, 1'b1, 1'b0, 32'hA5A5A5A5, 2});
        tbl.push_back('{0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h11111111, 2});
        tbl.push_back('{0, 1'b1, 8'h20, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h11111111, 2});
        tbl.push_back('{0, 1'b0, 8'hFF, 32'h00000000, 1'b0, 1'b1, 32'h11111111, 2});
        tbl.push_back('{0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h11111111, 2});
        tbl.push_back('{1, 1'b1, 8'h20, 32'hCAFEF00D, 1'b1, 1'b0, 32'h00000000, 2});
        tbl.push_back('{1, 1'b0, 8'h20, 32'h00000000, 1'b1, 1'b0, 32'hCAFEF00D, 2});
        tbl.push_back('{1, 1'b0, 8'h45, 32'h00000000, 1'b0, 1'b1, 32'hCAFEF00D, 2});
        tbl.push_back('{1, 1'b1, 8'h3F, 32'h0BADBEEF, 1'b1, 1'b0, 32'hCAFEF00D, 2});
        tbl.push_back('{1, 1'b0, 8'h3F, 32'h00000000, 1'b1, 1'b0, 32'h0BADBEEF, 2});
        tbl.push_back('{1, 1'b1, 8'h1F, 32'h55555555, 1'b0, 1'b1, 32'h0BADBEEF, 2});
        tbl.push_back('{1, 1'b0, 8'h3F, 32'h00000000, 1'b1, 1'b0, 32'h0BADBEEF, 2});
        tbl.push_back('{1, 1'b0, 8'h40, 32'h00000000, 1'b0, 1'b1, 32'h0BADBEEF, 2});
        tbl.push_back('{2, 1'b1, 8'h02, 32'hAAAA5555, 1'b1, 1'b0, 32'h00000000, 4});
        tbl.push_back('{2, 1'b0, 8'h02, 32'h00000000, 1'b1, 1'b0, 32'hAAAA5555, 4});
        tbl.push_back('{3, 1'b1, 8'h1F, 32'h13579BDF, 1'b1, 1'b0, 32'h00000000, 1});
        tbl.push_back('{3, 1'b0, 8'h1F, 32'h00000000, 1'b1, 1'b0, 32'h13579BDF, 1});

        foreach (tbl[i]) begin
            k = tbl[i].k;
            xfer(k, tbl[i].w, tbl[i].a, tbl[i].d, lat);
            tag = $sformatf("v%0d", i);
            check({tag, "_ack"},  ackv[k],  tbl[i].ack);
            check({tag, "_err"},  errv[k],  tbl[i].err);
            check({tag, "_dout"}, doutv[k], tbl[i].dout);
            check({tag, "_lat"},  lat,      tbl[i].lat);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_pulse"}, {ackv[k], errv[k]}, 2'b00);
        end

        // Abort on instance 2 (3 wait states): drop select in the 2nd WAIT cycle.
        sel[2] = 1'b1; wr[2] = 1'b1; addr[2] = 8'h02; din[2] = 32'h12345678;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        sel[2] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            seen |= ackv[2] | errv[2];
        end
        check("abort_no_ack", seen, 1'b0);
        check("abort_dout", doutv[2], 32'hAAAA5555);
        xfer(2, 1'b0, 8'h02, 32'h0, lat);
        check("abort_rd_ack", ackv[2], 1'b1);
        check("abort_rd_data", doutv[2], 32'hAAAA5555);
        check("abort_rd_lat", lat, 4);

        // Back-to-back on instance 3 (no wait states), select held high.
        sel[3] = 1'b1; wr[3] = 1'b1; addr[3] = 8'h1F; din[3] = 32'h2468ACE0;
        @(posedge clk); @(negedge clk);
        check("b2b_done_noack", ackv[3], 1'b0);
        @(posedge clk); @(negedge clk);
        check("b2b_wr_ack", ackv[3], 1'b1);
        wr[3] = 1'b0;
        @(posedge clk); @(negedge clk);
        check("b2b_gap", ackv[3], 1'b0);
        @(posedge clk); @(negedge clk);
        check("b2b_rd_ack", ackv[3], 1'b1);
        check("b2b_rd_data", doutv[3], 32'h2468ACE0);
        sel[3] = 1'b0;
        @(posedge clk); @(negedge clk);

        // Captured-field immunity on instance 0.
        sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h03; din[0] = 32'h03030303;
        @(posedge clk); @(negedge clk);
        addr[0] = 8'h07; din[0] = 32'hFFFFFFFF; wr[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("imm_ack", ackv[0], 1'b1);
        check("imm_dout_unchanged", doutv[0], 32'h11111111);
        sel[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        xfer(0, 1'b0, 8'h03, 32'h0, lat);
        check("imm_rd03", doutv[0], 32'h03030303);
        xfer(0, 1'b0, 8'h07, 32'h0, lat);
        check("imm_rd07", doutv[0], 32'h77777777);

        // Asynchronous reset between edges while instance 0 is in WAIT.
        sel[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h00; din[0] = 32'hEEEEEEEE;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async0", {ackv[0], errv[0], doutv[0]}, 64'h0);
        check("rst_async1", doutv[1], 32'h0);
        #1 reset = 1'b0;
        sel[0] = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 8'h00, 32'h0, lat);
        check("rst_rd_ack", ackv[0], 1'b1);
        check("rst_rd_data", doutv[0], 32'h11111111);
        check("rst_rd_lat", lat, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_slave_mem.md
BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: first bus address owned by this slave, aligned to 32.
REQ-002 Parameter WAIT_CYCLES, default 1: number of wait states inserted before a transfer completes; legal range 0..7.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port S_sel  input  1  slave select from the bus address decoder; high requests a transfer.
REQ-006 Port S_wr  input  1  transfer direction: 1 = write, 0 = read.
REQ-007 Port S_address  input  8  bus address of the transfer.
REQ-008 Port S_din  input  32  write data.
REQ-009 Port S_dout  output  32  read data, registered.
REQ-010 Port S_ack  output  1  one-cycle completion pulse for the transfer.
REQ-011 Port S_err  output  1  one-cycle error pulse, in place of S_ack, for an out-of-range address.

Function
REQ-012 Storage SHALL be 32 words x 32 bits, indexed by (S_address - BASE_ADDR)[4:0].
REQ-013 The state machine SHALL have the states IDLE, WAIT, DONE.
REQ-014 IDLE, S_sel=1 at a clock edge:
  - capture S_wr, S_address and S_din into request registers;
  - load the wait counter with WAIT_CYCLES;
  - go to WAIT if WAIT_CYCLES>0, else go to DONE.
REQ-015 WAIT: decrement the counter each cycle; when the counter reaches 1 and S_sel=1, go to DONE.
REQ-016 WAIT or DONE with S_sel=0 at a clock edge:
  - abort and return to IDLE;
  - no memory write, no S_ack, no S_err;
  - S_dout holds its previous value.
REQ-017 DONE with S_sel=1, in-range captured address (BASE_ADDR <= addr < BASE_ADDR+32):
  - write: store the captured data at the captured index;
  - read: load mem[index] into S_dout;
  - S_ack=1 for exactly that one cycle;
  - return to IDLE.
REQ-018 DONE with S_sel=1, out-of-range captured address:
  - S_err=1 for one cycle;
  - no memory write; S_dout is unchanged;
  - return to IDLE.
REQ-019 Completion latency from the S_sel capture edge to the S_ack/S_err edge SHALL be WAIT_CYCLES+1 clocks.
REQ-020 Captured request fields SHALL be immune to S_address, S_wr and S_din changes after the capture edge.
REQ-021 After a completion, S_sel still high in IDLE SHALL start a new transfer, so back-to-back transfers need no idle cycle beyond IDLE itself.
REQ-022 S_ack and S_err SHALL never be high in the same cycle.
REQ-023 Address arithmetic SHALL be 8-bit unsigned and SHALL NOT wrap: BASE_ADDR+32 is compared in 9 bits.

Reset
REQ-024 While reset=1, independent of clk:
  - state=IDLE, wait counter=0;
  - S_dout=32'h0, S_ack=0, S_err=0.
REQ-025 Memory contents SHALL NOT be cleared by reset; verification SHALL write each word before reading it.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no memory write, and the first post-reset edge with S_sel=1 SHALL start a fresh transfer.

Verification
REQ-027 WAIT_CYCLES=1, BASE_ADDR=8'h00: write 32'hDEADBEEF to 8'h05 -> S_ack high on the 2nd edge after capture; a later read of 8'h05 -> S_dout=32'hDEADBEEF together with S_ack.
REQ-028 BASE_ADDR=8'h20: read of 8'h45 -> S_err pulses once after WAIT_CYCLES+1 clocks; S_ack stays 0; S_dout unchanged.
REQ-029 WAIT_CYCLES=3: S_sel dropped in the 2nd WAIT cycle of a write of 32'h12345678 to 8'h02 -> no S_ack; a subsequent read of 8'h02 returns the prior contents.
REQ-030 WAIT_CYCLES=0, S_sel held high across a write of 8'h1F then a read of 8'h1F -> S_ack pulses on consecutive completion cycles; the read returns the written data.
REQ-031 reset pulsed asynchronously between clock edges during WAIT -> S_ack, S_err and S_dout go to 0 immediately; no write occurs.
REQ-032 S_address changed to 8'h07 one cycle after capturing a write to 8'h03 -> the write lands at 8'h03 only.
